// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU port and a loader/debug port onto one synchronous-read memory.
// Build option ARB_ROUND_ROBIN_EN: ties alternate between the ports instead of the loader winning.
module mem_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  output logic       c_gnt,
  output logic       c_rvalid,
  output logic [7:0] c_rdata,
  input  logic       l_req,
  input  logic       l_we,
  input  logic [7:0] l_addr,
  input  logic [7:0] l_wdata,
  output logic       l_gnt,
  output logic       l_rvalid,
  output logic [7:0] l_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we,
  input  logic [7:0] mem_dout,
  output logic       busy
);

  // state     | meaning
  // ST_IDLE   | waiting for a request; winner is latched on the next edge
  // ST_ACCESS | address/data/we on the memory bus, winner's gnt high
  // ST_RESP   | read data arriving from memory, captured into owner's rdata
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       own_l_q, own_l_d;
  logic       c_gnt_q, c_gnt_d;
  logic       l_gnt_q, l_gnt_d;
  logic       c_rvalid_q, c_rvalid_d;
  logic       l_rvalid_q, l_rvalid_d;
  logic [7:0] c_rdata_q, c_rdata_d;
  logic [7:0] l_rdata_q, l_rdata_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_din_q, mem_din_d;
  logic       mem_we_q, mem_we_d;
  logic       busy_q, busy_d;
  logic       pick_l;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_l_q, last_l_d;

  // On a tie the port that did not win last time goes first.
  assign pick_l = l_req & (~c_req | ~last_l_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_l_q <= 1'b1;
    end else begin
      last_l_q <= last_l_d;
    end
  end
`else
  assign pick_l = l_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      own_l_q    <= 1'b0;
      c_gnt_q    <= 1'b0;
      l_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= 8'h00;
      l_rdata_q  <= 8'h00;
      mem_addr_q <= 8'h00;
      mem_din_q  <= 8'h00;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_l_q    <= own_l_d;
      c_gnt_q    <= c_gnt_d;
      l_gnt_q    <= l_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  // Every output register is loaded with its value for the state being entered.
  always_comb begin
    state_d    = state_q;
    own_l_d    = own_l_q;
    c_gnt_d    = 1'b0;
    l_gnt_d    = 1'b0;
    c_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    l_rdata_d  = l_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_l_d   = last_l_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (c_req | l_req) begin
          state_d    = ST_ACCESS;
          own_l_d    = pick_l;
          mem_addr_d = pick_l ? l_addr  : c_addr;
          mem_din_d  = pick_l ? l_wdata : c_wdata;
          mem_we_d   = pick_l ? l_we    : c_we;
          c_gnt_d    = ~pick_l;
          l_gnt_d    = pick_l;
`ifdef ARB_ROUND_ROBIN_EN
          last_l_d   = pick_l;
`endif
        end
      end
      ST_ACCESS: begin
        // mem_we_q still holds the latched write qualifier during ACCESS.
        state_d = mem_we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (own_l_q) begin
          l_rdata_d  = mem_dout;
          l_rvalid_d = 1'b1;
        end else begin
          c_rdata_d  = mem_dout;
          c_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign c_gnt    = c_gnt_q;
  assign l_gnt    = l_gnt_q;
  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random requests on both ports, checked every cycle
// against a transaction-schedule reference model (honours ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;

  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       c_req, c_we, l_req, l_we;
  logic [7:0] c_addr, c_wdata, l_addr, l_wdata;
  logic       c_gnt, c_rvalid, l_gnt, l_rvalid, mem_we, busy;
  logic [7:0] c_rdata, l_rdata, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Shared synchronous-read memory seen by the DUT.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: per-cycle schedule of expected events.
  bit         e_gnt  [2][MAXC];
  bit         e_rv   [2][MAXC];
  bit         e_rset [2][MAXC];
  logic [7:0] e_rdat [2][MAXC];
  bit         e_we   [MAXC];
  bit         e_busy [MAXC];
  bit         e_aset [MAXC];
  logic [7:0] e_addr [MAXC];
  logic [7:0] e_din  [MAXC];
  bit         e_wr   [MAXC];
  logic [7:0] e_wa   [MAXC];
  logic [7:0] e_wd   [MAXC];
  logic [7:0] ref_mem [256];
  logic [7:0] cur_addr, cur_din;
  logic [7:0] cur_rd [2];
  int         free_at;
`ifdef ARB_ROUND_ROBIN_EN
  bit         last_l;
`endif

  bit         p_req [2];
  bit         p_we  [2];
  logic [7:0] p_addr [2];
  logic [7:0] p_wd   [2];
  bit         rand_en, auto_clr;
  int         gcnt [2];
  int         rvcnt [2];
  int         first_gp;

  task automatic check_outputs();
    if (e_wr[cyc]) ref_mem[e_wa[cyc]] = e_wd[cyc];
    if (e_aset[cyc]) begin
      cur_addr = e_addr[cyc];
      cur_din  = e_din[cyc];
    end
    for (int p = 0; p < 2; p++)
      if (e_rset[p][cyc]) cur_rd[p] = e_rdat[p][cyc];
    chk("c_gnt",    c_gnt,    e_gnt[0][cyc]);
    chk("l_gnt",    l_gnt,    e_gnt[1][cyc]);
    chk("c_rvalid", c_rvalid, e_rv[0][cyc]);
    chk("l_rvalid", l_rvalid, e_rv[1][cyc]);
    chk("mem_we",   mem_we,   e_we[cyc]);
    chk("busy",     busy,     e_busy[cyc]);
    chk("mem_addr", mem_addr, cur_addr);
    chk("mem_din",  mem_din,  cur_din);
    chk("c_rdata",  c_rdata,  cur_rd[0]);
    chk("l_rdata",  l_rdata,  cur_rd[1]);
    if (c_gnt === 1'b1) begin gcnt[0]++; if (first_gp < 0) first_gp = 0; end
    if (l_gnt === 1'b1) begin gcnt[1]++; if (first_gp < 0) first_gp = 1; end
    if (c_rvalid === 1'b1) rvcnt[0]++;
    if (l_rvalid === 1'b1) rvcnt[1]++;
  endtask

  task automatic check_reset_vals();
    chk("rst_c_gnt",    c_gnt,    0);
    chk("rst_l_gnt",    l_gnt,    0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_mem_we",   mem_we,   0);
    chk("rst_busy",     busy,     0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din",  mem_din,  0);
    chk("rst_c_rdata",  c_rdata,  0);
    chk("rst_l_rdata",  l_rdata,  0);
  endtask

  task automatic drive();
    c_req = p_req[0]; c_we = p_we[0]; c_addr = p_addr[0]; c_wdata = p_wd[0];
    l_req = p_req[1]; l_we = p_we[1]; l_addr = p_addr[1]; l_wdata = p_wd[1];
  endtask

  // Requests present in cycle k while the arbiter is free are served:
  // gnt at k+1, write lands at end of k+1, read data valid at k+3.
  task automatic schedule();
    int w;
    if (cyc >= free_at && (p_req[0] || p_req[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (p_req[0] && p_req[1]) w = last_l ? 0 : 1;
      else                      w = p_req[1] ? 1 : 0;
      last_l = (w == 1);
`else
      w = p_req[1] ? 1 : 0;
`endif
      e_gnt[w][cyc+1] = 1'b1;
      e_busy[cyc+1]   = 1'b1;
      e_aset[cyc+1]   = 1'b1;
      e_addr[cyc+1]   = p_addr[w];
      e_din[cyc+1]    = p_wd[w];
      e_we[cyc+1]     = p_we[w];
      if (p_we[w]) begin
        e_wr[cyc+2] = 1'b1;
        e_wa[cyc+2] = p_addr[w];
        e_wd[cyc+2] = p_wd[w];
        free_at = cyc + 2;
      end else begin
        e_busy[cyc+2]    = 1'b1;
        e_rv[w][cyc+3]   = 1'b1;
        e_rset[w][cyc+3] = 1'b1;
        e_rdat[w][cyc+3] = ref_mem[p_addr[w]];
        free_at = cyc + 3;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (auto_clr && e_gnt[p][cyc]) p_req[p] = 1'b0;
      if (rand_en) begin
        if (p_req[p]) begin
          if ($urandom_range(0, 15) == 0) p_req[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          p_req[p]  = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                  : 8'($urandom_range(0, 255));
          p_wd[p]   = 8'($urandom_range(0, 255));
        end
      end
    end
    drive();
    schedule();
    @(posedge clk);
    cyc++;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    check_outputs();
    #2;
    reset_n = 1'b0;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    drive();
    #1;
    check_reset_vals();
    for (int j = cyc + 1; j < MAXC; j++) begin
      e_gnt[0][j] = 0; e_gnt[1][j] = 0; e_rv[0][j] = 0; e_rv[1][j] = 0;
      e_rset[0][j] = 0; e_rset[1][j] = 0; e_we[j] = 0; e_busy[j] = 0;
      e_aset[j] = 0; e_wr[j] = 0;
    end
    cur_addr = 8'h00; cur_din = 8'h00; cur_rd[0] = 8'h00; cur_rd[1] = 8'h00;
    free_at = cyc + 1;
`ifdef ARB_ROUND_ROBIN_EN
    last_l = 1'b1;
`endif
    @(posedge clk);
    cyc++;
  endtask

  task automatic req_once(input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      ram[i] = v;
      ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = 8'h00; p_wd[p] = 8'h00;
      gcnt[p] = 0; rvcnt[p] = 0; cur_rd[p] = 8'h00;
    end
    cur_addr = 8'h00; cur_din = 8'h00;
    cyc = 0; free_at = 0; first_gp = -1; auto_clr = 1'b1; rand_en = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_l = 1'b1;
`endif
    reset_n = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    repeat (2) step();

    // CPU write A5 to 10
    req_once(0, 1'b1, 8'h10, 8'hA5);
    repeat (4) step();
    chk("ram_10", ram[8'h10], 8'hA5);

    // CPU read back 10
    rvcnt[0] = 0; rvcnt[1] = 0;
    req_once(0, 1'b0, 8'h10, 8'h00);
    repeat (5) step();
    chk("c_rv_cnt", rvcnt[0], 1);
    chk("l_rv_cnt", rvcnt[1], 0);
    chk("c_rdata_10", c_rdata, 8'hA5);

    // loader write 3C to FF, CPU read FF
    req_once(1, 1'b1, 8'hFF, 8'h3C);
    repeat (3) step();
    req_once(0, 1'b0, 8'hFF, 8'h00);
    repeat (5) step();
    chk("c_rdata_ff", c_rdata, 8'h3C);

    // one-cycle CPU pulse during RESP of a loader read is dropped
    req_once(1, 1'b0, 8'h20, 8'h00);
    repeat (2) step();
    gcnt[0] = 0;
    req_once(0, 1'b0, 8'h30, 8'h00);
    step();
    p_req[0] = 1'b0;
    repeat (4) step();
    chk("c_gnt_resp_pulse", gcnt[0], 0);

    // reset during RESP of a CPU read aborts it
    req_once(0, 1'b0, 8'h10, 8'h00);
    repeat (2) step();
    rvcnt[0] = 0;
    reset_pulse();
    repeat (4) step();
    chk("c_rv_after_rst", rvcnt[0], 0);
    req_once(0, 1'b0, 8'h10, 8'h00);
    repeat (5) step();
    chk("c_rv_next_req", rvcnt[0], 1);

    // both ports request reads continuously for 12 cycles, fresh from reset
    reset_pulse();
    gcnt[0] = 0; gcnt[1] = 0; first_gp = -1; auto_clr = 1'b0;
    req_once(0, 1'b0, 8'h10, 8'h00);
    req_once(1, 1'b0, 8'hFF, 8'h00);
    repeat (12) step();
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    repeat (5) step();
    auto_clr = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_c_gnts", gcnt[0], 2);
    chk("tie_l_gnts", gcnt[1], 2);
    chk("tie_first", first_gp, 0);
`else
    chk("tie_c_gnts", gcnt[0], 0);
    chk("tie_l_gnts", gcnt[1], 4);
    chk("tie_first", first_gp, 1);
`endif

    // random traffic with one mid-run reset
    rand_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_pulse();
      else          step();
    end
    rand_en = 1'b0;
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
